// File: rtl/ip_id_repeat_counter.sv
// Repeat-rate monitor for an extracted header field (e.g. IPv4 ID): counts samples that
// match any of the last HIST_DEPTH samples, and publishes the count once per 2^WINDOW_LOG2 samples.
module ip_id_repeat_counter #(
  parameter int N_BITS      = 16,
  parameter int HIST_DEPTH  = 4,
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [N_BITS-1:0]      field,
  output logic [WINDOW_LOG2:0]   rep_rate,
  output logic                   ready
);

  localparam logic [WINDOW_LOG2-1:0] LP_CNT_LAST = '1;

  logic [N_BITS-1:0]      r_hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]  r_occ;
  logic [WINDOW_LOG2-1:0] r_sample_cnt;
  logic [WINDOW_LOG2:0]   r_rep_acc;
  logic [WINDOW_LOG2:0]   r_rep_rate;
  logic                   r_ready;

  logic [N_BITS-1:0]      w_hist_in [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]  w_occ_in;
  logic [HIST_DEPTH-1:0]  w_match;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_win_end;
  logic [WINDOW_LOG2:0]   w_acc_sum;

  assign w_accept  = valid && !clear;
  assign w_hit     = |w_match;
  assign w_win_end = w_accept && (r_sample_cnt == LP_CNT_LAST);
  assign w_acc_sum = r_rep_acc + {{WINDOW_LOG2{1'b0}}, w_hit};

  // Matching uses pre-shift contents, so a sample can never match itself;
  // an unoccupied entry (FILLING state) never contributes a hit.
  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign w_hist_in[gi] = field;
      assign w_occ_in[gi]  = 1'b1;
    end else begin : g_tail
      assign w_hist_in[gi] = r_hist[gi-1];
      assign w_occ_in[gi]  = r_occ[gi-1];
    end

    assign w_match[gi] = r_occ[gi] && (r_hist[gi] == field);

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        r_hist[gi] <= '0;
        r_occ[gi]  <= 1'b0;
      end else if (clear) begin
        r_occ[gi]  <= 1'b0;
      end else if (valid) begin
        r_hist[gi] <= w_hist_in[gi];
        r_occ[gi]  <= w_occ_in[gi];
      end
    end
  end

  // History survives a window boundary; only clear/reset empties it.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sample_cnt <= '0;
      r_rep_acc    <= '0;
      r_rep_rate   <= '0;
      r_ready      <= 1'b0;
    end else if (clear) begin
      r_sample_cnt <= '0;
      r_rep_acc    <= '0;
      r_ready      <= 1'b0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
      if (w_win_end) begin
        r_rep_rate <= w_acc_sum;
        r_rep_acc  <= '0;
        r_ready    <= 1'b1;
      end else begin
        r_rep_acc  <= w_acc_sum;
        r_ready    <= 1'b0;
      end
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign rep_rate = r_rep_rate;
  assign ready    = r_ready;

endmodule

// File: tb/tb_ip_id_repeat_counter.sv
// Directed bench for ip_id_repeat_counter with HIST_DEPTH=4, WINDOW_LOG2=3 (window of 8).
module tb_ip_id_repeat_counter;

  localparam int NB = 16;
  localparam int HD = 4;
  localparam int WL = 3;

  logic          sys_clk;
  logic          reset;
  logic          clear;
  logic          valid;
  logic [NB-1:0] field;
  logic [WL:0]   rep_rate;
  logic          ready;

  int n_checks;
  int n_errors;

  typedef struct {
    logic          v;
    logic          c;
    logic [NB-1:0] f;
    logic          exp_ready;
    logic [WL:0]   exp_rate;
  } vec_t;

  vec_t vecs[$];

  ip_id_repeat_counter #(.N_BITS(NB), .HIST_DEPTH(HD), .WINDOW_LOG2(WL)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clear   (clear),
    .valid   (valid),
    .field   (field),
    .rep_rate(rep_rate),
    .ready   (ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [WL:0] act, input logic [WL:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic c, input logic [NB-1:0] f,
                     input logic er, input logic [WL:0] rr);
    vec_t x;
    x.v = v; x.c = c; x.f = f; x.exp_ready = er; x.exp_rate = rr;
    vecs.push_back(x);
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic v, input logic c, input logic [NB-1:0] f);
    @(negedge sys_clk);
    valid = v; clear = c; field = f;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic async_reset_pulse();
    valid = 1'b0; clear = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_reset_rate", rep_rate, 4'd0);
    chk("async_reset_ready", {3'b0, ready}, 4'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0; clear = 1'b0; valid = 1'b0; field = '0;

    // Distinct 1..8: no hits.
    for (int i = 1; i <= 7; i++) add(1, 0, 16'(i), 0, 0);
    add(1, 0, 16'd8, 1, 0);
    add(0, 0, 16'd0, 0, 0);
    // 1,2,3,4,1,2,3,4: distance-4 matches hit (history holds 5..8 at start).
    for (int i = 1; i <= 4; i++) add(1, 0, 16'(i), 0, 0);
    for (int i = 1; i <= 3; i++) add(1, 0, 16'(i), 0, 0);
    add(1, 0, 16'd4, 1, 4);
    add(0, 0, 16'd0, 0, 4);
    // Clear with a valid sample: sample discarded, rep_rate held.
    add(1, 1, 16'd7, 0, 4);
    // Distance 5 misses.
    for (int i = 1; i <= 5; i++) add(1, 0, 16'(i), 0, 4);
    add(1, 0, 16'd1, 0, 4);
    add(1, 0, 16'd2, 0, 4);
    add(1, 0, 16'd3, 1, 0);
    add(0, 1, 16'd0, 0, 0);
    // Duplicate-history hits count once.
    for (int i = 0; i < 5; i++) add(1, 0, 16'd5, 0, 0);
    add(1, 0, 16'd1, 0, 0);
    add(1, 0, 16'd2, 0, 0);
    add(1, 0, 16'd3, 1, 4);
    // Clear right after window end: pulse not extended.
    add(0, 1, 16'd0, 0, 4);
    // All-equal: 7 then full-width 8.
    for (int i = 0; i < 7; i++) add(1, 0, 16'h00AA, 0, 4);
    add(1, 0, 16'h00AA, 1, 7);
    for (int i = 0; i < 7; i++) add(1, 0, 16'h00AA, 0, 7);
    add(1, 0, 16'h00AA, 1, 8);
    add(0, 0, 16'd0, 0, 8);
    // Clear mid-window together with a valid sample.
    for (int i = 0; i < 3; i++) add(1, 0, 16'd7, 0, 8);
    add(1, 1, 16'd7, 0, 8);
    for (int i = 0; i < 7; i++) add(1, 0, 16'd7, 0, 8);
    add(1, 0, 16'd7, 1, 7);
    add(0, 0, 16'd0, 0, 7);

    async_reset_pulse();

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].c, vecs[k].f);
      chk($sformatf("vec%0d_ready", k), {3'b0, ready}, {3'b0, vecs[k].exp_ready});
      chk($sformatf("vec%0d_rate", k), rep_rate, vecs[k].exp_rate);
    end

    // Reset mid-window loses the partial window.
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 16'(i));
      chk("prereset_ready", {3'b0, ready}, 4'd0);
    end
    async_reset_pulse();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 16'(i));
      chk("postreset_ready", {3'b0, ready}, (i == 8) ? 4'd1 : 4'd0);
    end
    chk("postreset_rate", rep_rate, 4'd0);

    // Idle gaps between eight 9s.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 16'd9);
      chk("gap_ready", {3'b0, ready}, (i == 8) ? 4'd1 : 4'd0);
      if (i < 8) begin
        int gaps;
        gaps = int'($urandom_range(0, 3));
        for (int g = 0; g < gaps; g++) begin
          step(0, 0, 16'd0);
          chk("gap_idle_ready", {3'b0, ready}, 4'd0);
        end
      end
    end
    chk("gap_rate", rep_rate, 4'd7);
    step(0, 0, 16'd0);
    chk("gap_after_ready", {3'b0, ready}, 4'd0);
    chk("gap_after_rate", rep_rate, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ip_id_repeat_counter.md
# ip_id_repeat_counter

Consumes the single-cycle `field`/`valid` strobe produced by a header-field extractor, such as the IPv4 identification field. Over fixed windows of extracted samples, it measures how often a value repeats one already seen within a short recent history. At the end of each window it publishes the repeat count as `rep_rate` with a one-cycle `ready` pulse, for the status display and for downstream covert-channel statistics.

## Interface
Parameters:
- `N_BITS`, 16: width of the monitored field.
- `HIST_DEPTH`, 4: number of most recent samples held for comparison. Must be ≥1.
- `WINDOW_LOG2`, 10: window length is 2^WINDOW_LOG2 valid samples. Must be ≥1.

Ports:
- `sys_clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous flush of history and of window state.
- `valid`  in  1: `field` carries a new sample this cycle. It may assert every cycle.
- `field`  in  N_BITS: sample value, sampled only when `valid`=1.
- `rep_rate`  out  WINDOW_LOG2+1: repeat count of the last completed window.
- `ready`  out  1: one-cycle pulse when `rep_rate` updates.

## Operation
- History is a shift register of HIST_DEPTH entries. Each entry has an occupancy bit. Entry 0 holds the newest sample.
- On an accepted sample (`valid`=1, `clear`=0):
  - `hit` = OR over all occupied entries of (entry == `field`). Duplicate entries still count as one hit.
  - The sample shifts into entry 0 and the oldest entry is dropped. The occupancy bit shifts in as 1.
  - `sample_cnt` (WINDOW_LOG2 bits) increments.
  - `rep_acc` (WINDOW_LOG2+1 bits) is increased by `hit`.
- Window end occurs on an accepted sample while `sample_cnt` == 2^WINDOW_LOG2−1. On that cycle:
  - `rep_rate` ← `rep_acc` + `hit`, and `ready` ← 1.
  - `sample_cnt` ← 0 and `rep_acc` ← 0.
  - History is retained, so the first sample of the next window can hit.
- Width rule: the maximum count is 2^WINDOW_LOG2, so the extra MSB on `rep_acc`/`rep_rate` is required. No saturation logic is needed.
- `clear`=1 has priority over `valid`. A sample presented in a clear cycle is discarded. On clear:
  - All occupancy bits go to 0.
  - `sample_cnt` and `rep_acc` go to 0.
  - `ready` goes to 0.
  - `rep_rate` holds its last value.
- State machine, two implicit states:
  - FILLING: one or more occupancy bits are 0. Unoccupied entries never produce a hit.
  - STEADY: all entries are occupied.
  - FILLING → STEADY after HIST_DEPTH accepted samples since reset or clear.
  - STEADY → FILLING only on `clear` or `reset`.
- Idle cycles (`valid`=0) change nothing except deasserting `ready`.

## Timing
- Reset values: `rep_rate`=0, `ready`=0, all history entries and occupancy bits 0, `sample_cnt`=0, `rep_acc`=0.
- Reset is asynchronous and may arrive mid-window. The window in progress is lost and no `ready` pulse is produced.
- Latency: `rep_rate`/`ready` are registered and are visible the cycle after the window-closing sample.
- `ready` is high for exactly one cycle per window. Back-to-back windows at full rate give `ready` pulses exactly 2^WINDOW_LOG2 cycles apart.
- Comparison is against the history contents before the current sample is shifted in. A sample never matches itself.
- Full throughput: one sample per cycle with no stalls and no backpressure.

## Test plan
All scenarios use HIST_DEPTH=4, WINDOW_LOG2=3 (window of 8), N_BITS=16.
1. Reset check: assert `reset` asynchronously, mid-cycle, for 2 cycles → `rep_rate`=0, `ready`=0. Then feed samples 1..7, reset, then samples 1..8 → exactly one `ready` pulse, after the 8th post-reset sample, with `rep_rate`=0.
2. All-distinct and all-equal windows:
   - Samples 0x0001..0x0008 back-to-back → `ready` one cycle after the 8th sample, `rep_rate`=0.
   - From a fresh reset, 16 consecutive samples of 0x00AA → first window `rep_rate`=7, second window `rep_rate`=8 (full-width value 4'b1000).
3. History depth boundary:
   - Samples 1,2,3,4,1,2,3,4 → `rep_rate`=4 (a match at distance 4 hits).
   - After reset, samples 1,2,3,4,5,1,2,3 → `rep_rate`=0 (distance 5 misses).
4. Idle gaps: samples 9,9,9,9,9,9,9,9 with 0–3 random idle cycles between them → `rep_rate`=7. `ready` comes one cycle after the 8th valid sample, and no pulse occurs elsewhere.
5. Clear mid-window:
   - Samples 7,7,7, then `clear` asserted together with a `valid` sample of 7, then eight samples of 7 → one `ready`, after the 8th post-clear sample, with `rep_rate`=7. The prior `rep_rate` is held throughout.
   - Clear asserted in the cycle after a window end → the `ready` pulse is already emitted and is not extended.
6. Duplicate-history hit: samples 5,5,5,5,5,1,2,3 → `rep_rate`=4. A sample matching several entries counts once.
